frame_sequencer: RTL and testbench

//  Top-level per-frame scheduler for the simulation core. Each frame it starts the FPS limiter and the

---
 rtl/frame_sequencer_pkg.sv | 23 ++
 rtl/frame_sequencer_unit_handshake.sv | 15 +
 rtl/frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared constants and state encoding for the per-frame scheduler.
package frame_sequencer_pkg;

    localparam int unsigned DELAY_WIDTH     = 24;
    localparam int unsigned FRAME_WIDTH_DEF = 16;
    localparam int unsigned GEN_WIDTH_DEF   = 16;

    typedef enum logic [3:0] {
        FS_IDLE,
        FS_FRAME_GO,
        FS_SIM_ACK,
        FS_SIM_WAIT,
        FS_DRAW_GO,
        FS_DRAW_ACK,
        FS_DRAW_WAIT,
        FS_EVO_GO,
        FS_EVO_ACK,
        FS_EVO_WAIT,
        FS_LIM_WAIT,
        FS_END
    } fs_state_t;

endpackage

// File: rtl/frame_sequencer_unit_handshake.sv
// Start/done gating for one worker unit. The caller skips the ACK cycle by holding
// waiting low until the unit has had a cycle to drop finished.
module frame_sequencer_unit_handshake (
    input  logic go,
    input  logic waiting,
    input  logic finished,
    output logic start,
    output logic done
);

    // Never launch a unit that is still busy.
    assign start = go & finished;
    assign done  = waiting & finished;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: sim + limiter, draw, periodic evolve, then wait for the limiter.
// Optional FRAME_PROFILE_EN adds work_cycles/overrun frame profiling outputs.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH = FRAME_WIDTH_DEF,
    parameter int unsigned GEN_WIDTH   = GEN_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   run,
    input  logic                   step,
    input  logic [FRAME_WIDTH-1:0] frames_per_gen,
    input  logic [DELAY_WIDTH-1:0] fps_delay,
    output logic                   sim_start,
    input  logic                   sim_finished,
    output logic                   draw_start,
    input  logic                   draw_finished,
    output logic                   evo_start,
    input  logic                   evo_finished,
    output logic                   lim_start,
    output logic [DELAY_WIDTH-1:0] lim_delay,
    input  logic                   lim_finished,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_WIDTH-1:0] frame_count,
    output logic [GEN_WIDTH-1:0]   generation
`ifdef FRAME_PROFILE_EN
    ,
    output logic [DELAY_WIDTH-1:0] work_cycles,
    output logic                   overrun
`endif
);

    fs_state_t state_q, state_d;

    logic [DELAY_WIDTH-1:0] lim_delay_q;
    logic [FRAME_WIDTH-1:0] frame_count_q;
    logic [GEN_WIDTH-1:0]   generation_q;
    logic                   evo_frame_q;

    logic all_finished;
    logic sim_done, draw_done, evo_done;
    logic launch;
    logic evolve_now;
    logic [FRAME_WIDTH:0] fc_next;
    logic [FRAME_WIDTH:0] fpg_eff;

    assign all_finished = sim_finished & draw_finished & evo_finished & lim_finished;

    frame_sequencer_unit_handshake u_sim_hs (
        .go      ((state_q == FS_FRAME_GO) & lim_finished),
        .waiting (state_q == FS_SIM_WAIT),
        .finished(sim_finished),
        .start   (sim_start),
        .done    (sim_done)
    );

    frame_sequencer_unit_handshake u_draw_hs (
        .go      (state_q == FS_DRAW_GO),
        .waiting (state_q == FS_DRAW_WAIT),
        .finished(draw_finished),
        .start   (draw_start),
        .done    (draw_done)
    );

    frame_sequencer_unit_handshake u_evo_hs (
        .go      (state_q == FS_EVO_GO),
        .waiting (state_q == FS_EVO_WAIT),
        .finished(evo_finished),
        .start   (evo_start),
        .done    (evo_done)
    );

    // The limiter starts together with the population update.
    assign lim_start = sim_start;

    // A zero period counts as one; ">=" also evolves when the live value shrank below the count.
    assign fc_next    = {1'b0, frame_count_q} + (FRAME_WIDTH + 1)'(1);
    assign fpg_eff    = (frames_per_gen == '0) ? (FRAME_WIDTH + 1)'(1) : {1'b0, frames_per_gen};
    assign evolve_now = (fc_next >= fpg_eff);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_IDLE:      if ((run | step) & all_finished) state_d = FS_FRAME_GO;
            FS_FRAME_GO:  if (sim_start) state_d = FS_SIM_ACK;
            FS_SIM_ACK:   state_d = FS_SIM_WAIT;
            FS_SIM_WAIT:  if (sim_done) state_d = FS_DRAW_GO;
            FS_DRAW_GO:   if (draw_start) state_d = FS_DRAW_ACK;
            FS_DRAW_ACK:  state_d = FS_DRAW_WAIT;
            FS_DRAW_WAIT: if (draw_done) state_d = evolve_now ? FS_EVO_GO : FS_LIM_WAIT;
            FS_EVO_GO:    if (evo_start) state_d = FS_EVO_ACK;
            FS_EVO_ACK:   state_d = FS_EVO_WAIT;
            FS_EVO_WAIT:  if (evo_done) state_d = FS_LIM_WAIT;
            FS_LIM_WAIT:  if (lim_finished) state_d = FS_END;
            FS_END:       state_d = (run & all_finished) ? FS_FRAME_GO : FS_IDLE;
            default:      state_d = FS_IDLE;
        endcase
    end

    assign launch = (state_d == FS_FRAME_GO) && (state_q != FS_FRAME_GO);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= FS_IDLE;
            lim_delay_q   <= '0;
            frame_count_q <= '0;
            generation_q  <= '0;
            evo_frame_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) lim_delay_q <= fps_delay;
            if (state_q == FS_FRAME_GO) evo_frame_q <= 1'b0;
            if (evo_done) begin
                frame_count_q <= '0;
                generation_q  <= generation_q + GEN_WIDTH'(1);
                evo_frame_q   <= 1'b1;
            end
            if ((state_q == FS_END) && !evo_frame_q) begin
                frame_count_q <= frame_count_q + FRAME_WIDTH'(1);
            end
        end
    end

    assign busy        = (state_q != FS_IDLE);
    assign frame_done  = (state_q == FS_END);
    assign lim_delay   = lim_delay_q;
    assign frame_count = frame_count_q;
    assign generation  = generation_q;

`ifdef FRAME_PROFILE_EN
    logic [DELAY_WIDTH-1:0] prof_cnt_q, work_cycles_q;
    logic                   lim_first_q, ovr_pend_q, overrun_q;
    logic                   counting;

    assign counting = (state_q != FS_IDLE) && (state_q != FS_FRAME_GO) &&
                      (state_q != FS_LIM_WAIT) && (state_q != FS_END);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            prof_cnt_q    <= '0;
            work_cycles_q <= '0;
            lim_first_q   <= 1'b0;
            ovr_pend_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (state_q == FS_FRAME_GO) begin
                prof_cnt_q <= DELAY_WIDTH'(1);
            end else if (counting && (prof_cnt_q != '1)) begin
                prof_cnt_q <= prof_cnt_q + DELAY_WIDTH'(1);
            end
            // Overrun is judged on the first LIM_WAIT cycle only.
            lim_first_q <= (state_d == FS_LIM_WAIT) && (state_q != FS_LIM_WAIT);
            if ((state_q == FS_LIM_WAIT) && lim_first_q) ovr_pend_q <= lim_finished;
            if (state_q == FS_END) begin
                work_cycles_q <= prof_cnt_q;
                overrun_q     <= ovr_pend_q;
            end
        end
    end

    assign work_cycles = work_cycles_q;
    assign overrun     = overrun_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: stimulus queues expected frames, a monitor checks them.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int FW = 16;
    localparam int GW = 16;

    logic                   clock, resetn, run, step;
    logic [FW-1:0]          frames_per_gen;
    logic [DELAY_WIDTH-1:0] fps_delay;
    logic                   sim_start, sim_finished, draw_start, draw_finished;
    logic                   evo_start, evo_finished, lim_start, lim_finished;
    logic [DELAY_WIDTH-1:0] lim_delay;
    logic                   busy, frame_done;
    logic [FW-1:0]          frame_count;
    logic [GW-1:0]          generation;
`ifdef FRAME_PROFILE_EN
    logic [DELAY_WIDTH-1:0] work_cycles;
    logic                   overrun;
`endif

    frame_sequencer #(.FRAME_WIDTH(FW), .GEN_WIDTH(GW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .run           (run),
        .step          (step),
        .frames_per_gen(frames_per_gen),
        .fps_delay     (fps_delay),
        .sim_start     (sim_start),
        .sim_finished  (sim_finished),
        .draw_start    (draw_start),
        .draw_finished (draw_finished),
        .evo_start     (evo_start),
        .evo_finished  (evo_finished),
        .lim_start     (lim_start),
        .lim_delay     (lim_delay),
        .lim_finished  (lim_finished),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .generation    (generation)
`ifdef FRAME_PROFILE_EN
        ,
        .work_cycles   (work_cycles),
        .overrun       (overrun)
`endif
    );

    typedef struct {
        int len;   // cycles from sim_start to frame_done
        int gap;   // cycles since previous frame_done (0 = not checked)
        int evo;
        int fc;
        int gen;
        int work;
        int ovr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    logic sim_hold = 1'b0;
    logic [3:0] ustart;
    logic [3:0] ufin;
    int   ucnt[4];
    int   ulat[3];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Unit models: drop finished after start, raise it again lat cycles after the start pulse.
    function automatic int unit_lat(input int i);
        return (i == 3) ? int'(lim_delay) : ulat[i];
    endfunction

    assign ustart        = {lim_start, evo_start, draw_start, sim_start};
    assign sim_finished  = ufin[0] & ~sim_hold;
    assign draw_finished = ufin[1];
    assign evo_finished  = ufin[2];
    assign lim_finished  = ufin[3];

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (!resetn) begin
                ufin[i] <= 1'b1;
                ucnt[i] <= 0;
            end else if (ustart[i]) begin
                ufin[i] <= 1'b0;
                ucnt[i] <= unit_lat(i) - 1;
            end else if (!ufin[i]) begin
                if (ucnt[i] <= 1) ufin[i] <= 1'b1;
                else ucnt[i] <= ucnt[i] - 1;
            end
        end
    end

    initial begin : monitor
        int   last_start;
        int   last_done;
        logic evo_seen;
        logic pend;
        exp_t cur;
        last_start = 0;
        last_done  = 0;
        evo_seen   = 1'b0;
        pend       = 1'b0;
        forever begin
            @(negedge clock);
            if (pend) begin
                check("frame_count", int'(frame_count), cur.fc);
                check("generation", int'(generation), cur.gen);
`ifdef FRAME_PROFILE_EN
                check("work_cycles", int'(work_cycles), cur.work);
                check("overrun", int'(overrun), cur.ovr);
`endif
                pend = 1'b0;
            end
            if (sim_start || lim_start) check("lim_sim_together", int'(lim_start), int'(sim_start));
            if (sim_start) begin
                check("sim_start_idle", int'(sim_finished), 1);
                last_start = cyc;
                evo_seen   = 1'b0;
                start_cnt++;
            end
            if (draw_start) check("draw_start_idle", int'(draw_finished), 1);
            if (evo_start) begin
                check("evo_start_idle", int'(evo_finished), 1);
                evo_seen = 1'b1;
            end
            if (frame_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", sb.size(), 1);
                end else begin
                    cur = sb.pop_front();
                    check("frame_len", cyc - last_start, cur.len);
                    if (cur.gap != 0) check("frame_gap", cyc - last_done, cur.gap);
                    check("evo_this_frame", int'(evo_seen), cur.evo);
                    pend = 1'b1;
                end
                last_done = cyc;
                done_cnt++;
            end
        end
    end

    task automatic push(input int len, input int gap, input int evo, input int fc,
                        input int gen, input int work, input int ovr);
        exp_t e;
        e.len = len; e.gap = gap; e.evo = evo; e.fc = fc;
        e.gen = gen; e.work = work; e.ovr = ovr;
        sb.push_back(e);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int i = 0;
        while (start_cnt < n && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (start_cnt < n) check("timeout_start", start_cnt, n);
    endtask

    task automatic wait_done(input int n, input int budget);
        int i = 0;
        while (done_cnt < n && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (done_cnt < n) check("timeout_done", done_cnt, n);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clock);
            i++;
        end
        check("idle_after_frames", int'(busy), 0);
    endtask

    initial begin : stim
        int s0;
        int d0;
        int k;
        resetn         = 1'b0;
        run            = 1'b0;
        step           = 1'b0;
        frames_per_gen = 16'd1000;
        fps_delay      = 24'd100;
        ulat[0] = 10; ulat[1] = 10; ulat[2] = 10;
        repeat (3) @(negedge clock);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_count", int'(frame_count), 0);
        check("reset_generation", int'(generation), 0);
        check("reset_lim_delay", int'(lim_delay), 0);
        check("reset_frame_done", int'(frame_done), 0);
        resetn = 1'b1;

        // Limiter-bound frames: period delay+2.
        s0 = start_cnt; d0 = done_cnt;
        push(101, 0, 0, 1, 0, 22, 0);
        push(101, 102, 0, 2, 0, 22, 0);
        push(101, 102, 0, 3, 0, 22, 0);
        run = 1'b1;
        wait_starts(s0 + 3, 400);
        check("lim_delay_latched", int'(lim_delay), 100);
        run = 1'b0;
        wait_done(d0 + 3, 400);
        wait_idle(50);

        // Work-bound frames: sim dominates a short delay.
        fps_delay = 24'd5;
        ulat[0]   = 50;
        s0 = start_cnt; d0 = done_cnt;
        push(63, 0, 0, 4, 0, 62, 1);
        push(63, 64, 0, 5, 0, 62, 1);
        run = 1'b1;
        wait_starts(s0 + 2, 200);
        run = 1'b0;
        wait_done(d0 + 2, 200);
        wait_idle(50);

        // Generations every 3 frames.
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        frames_per_gen = 16'd3;
        fps_delay = 24'd4;
        ulat[0] = 3; ulat[1] = 3; ulat[2] = 3;
        s0 = start_cnt; d0 = done_cnt;
        push(9, 0, 0, 1, 0, 8, 1);
        push(9, 10, 0, 2, 0, 8, 1);
        push(13, 14, 1, 0, 1, 12, 1);
        push(9, 10, 0, 1, 1, 8, 1);
        push(9, 10, 0, 2, 1, 8, 1);
        push(13, 14, 1, 0, 2, 12, 1);
        push(9, 10, 0, 1, 2, 8, 1);
        run = 1'b1;
        wait_starts(s0 + 7, 300);
        run = 1'b0;
        wait_done(d0 + 7, 300);
        wait_idle(50);

        // Reset in the middle of a long draw.
        ulat[1] = 20;
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        k = 0;
        while (!draw_start && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("reach_draw", int'(draw_start), 1);
        repeat (3) @(negedge clock);
        check("pre_reset_busy", int'(busy), 1);
        resetn = 1'b0;
        @(negedge clock);
        check("abort_busy", int'(busy), 0);
        check("abort_starts", int'({sim_start, draw_start, evo_start, lim_start}), 0);
        check("abort_frame_done", int'(frame_done), 0);
        check("abort_lim_delay", int'(lim_delay), 0);
        check("abort_frame_count", int'(frame_count), 0);
        check("abort_generation", int'(generation), 0);
        resetn = 1'b1;

        // Single step; a second step while busy is ignored.
        ulat[1] = 3;
        fps_delay = 24'd10;
        frames_per_gen = 16'd1000;
        d0 = done_cnt;
        push(11, 0, 0, 1, 0, 8, 0);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        repeat (5) @(negedge clock);
        check("step_busy", int'(busy), 1);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        wait_done(d0 + 1, 100);
        repeat (40) @(negedge clock);
        check("step_frames", done_cnt - d0, 1);
        check("step_idle", int'(busy), 0);

        // Busy sim at idle holds off the frame; release starts it next cycle.
        sim_hold = 1'b1;
        run = 1'b1;
        s0 = start_cnt; d0 = done_cnt;
        repeat (10) @(negedge clock);
        check("hold_no_start", start_cnt - s0, 0);
        check("hold_idle", int'(busy), 0);
        push(11, 0, 0, 2, 0, 8, 0);
        sim_hold = 1'b0;
        @(negedge clock);
        check("release_start", int'(sim_start), 1);
        run = 1'b0;
        wait_done(d0 + 1, 100);
        wait_idle(50);

        repeat (5) @(negedge clock);
        check("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
